// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and bus widths for the mem_arbiter slice
package mem_arb_pkg;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int CW = 4;
    typedef enum logic [1:0] {IDLE, CPU_OWN, EXT_RD, EXT_WR} arb_state_t;
endpackage

// File: rtl/mem_arb_starve_cnt.sv
// mem_arb_starve_cnt: counts contended CPU wins, saturating at MAX; clears on external grant
module mem_arb_starve_cnt
    import mem_arb_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);
    logic [CW-1:0] cnt;

    assign sat = cnt == CW'(MAX);

    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc && !sat) cnt <= cnt + CW'(1);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one data RAM between the CPU and an external loader/debug port.
// Define MEM_ARB_STARVE_EN to force the external port through after STARVE_MAX contended CPU wins.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_rd_req,
    input  logic [AW-1:0] cpu_rd_addr,
    input  logic [SW-1:0] cpu_wr_sel,
    input  logic [AW-1:0] cpu_wr_addr,
    input  logic [DW-1:0] cpu_wr_data,
    output logic [DW-1:0] cpu_rd_data,
    output logic          cpu_stall,
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic [SW-1:0] ext_sel,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic          ext_gnt,
    output logic          ext_rvalid,
    output logic [DW-1:0] ext_rdata,
    output logic          ram_ren,
    output logic [AW-1:0] ram_r_addr,
    output logic [SW-1:0] ram_wen,
    output logic [AW-1:0] ram_w_addr,
    output logic [DW-1:0] ram_w_data,
    input  logic [DW-1:0] ram_r_data
);
    arb_state_t    state, state_nx;
    logic          cpu_wr, cpu_req, arb_open, starve_sat, ext_go, cpu_go;
    logic [SW-1:0] sel_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q, rdata_q;

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("mem_arbiter: STARVE_MAX must be in 1..15");
    end

    assign cpu_wr   = |cpu_wr_sel;
    assign cpu_req  = cpu_rd_req | cpu_wr;
    assign arb_open = (state == IDLE) || (state == CPU_OWN);

`ifdef MEM_ARB_STARVE_EN
    logic starve_inc;
    assign starve_inc = arb_open & cpu_req & ext_req & ~starve_sat;
    mem_arb_starve_cnt #(.MAX(STARVE_MAX)) u_starve (
        .clk (clk),
        .rst (rst),
        .inc (starve_inc),
        .clr (ext_go),
        .sat (starve_sat)
    );
`else
    assign starve_sat = 1'b0;
`endif

    assign ext_go      = arb_open & ext_req & (~cpu_req | starve_sat);
    assign cpu_go      = arb_open & ~ext_go;
    assign ext_gnt     = ext_go;
    assign cpu_stall   = cpu_req & ~cpu_go;
    assign ext_rvalid  = state == EXT_RD;
    assign ext_rdata   = ext_rvalid ? ram_r_data : rdata_q;
    assign cpu_rd_data = ram_r_data;

    // EXT_WR re-issues the write latched at grant, so the CPU is held off for that cycle too
    always_comb begin
        state_nx   = (arb_open && cpu_req) ? CPU_OWN : IDLE;
        ram_ren    = 1'b0;
        ram_r_addr = '0;
        ram_wen    = '0;
        ram_w_addr = '0;
        ram_w_data = '0;
        if (ext_go) begin
            state_nx   = ext_we ? EXT_WR : EXT_RD;
            ram_ren    = ~ext_we;
            ram_r_addr = ext_we ? '0 : ext_addr;
            ram_wen    = ext_we ? ext_sel : '0;
            ram_w_addr = ext_we ? ext_addr : '0;
            ram_w_data = ext_we ? ext_wdata : '0;
        end else if (cpu_go) begin
            ram_ren    = cpu_rd_req;
            ram_r_addr = cpu_rd_req ? cpu_rd_addr : '0;
            ram_wen    = cpu_wr_sel;
            ram_w_addr = cpu_wr ? cpu_wr_addr : '0;
            ram_w_data = cpu_wr ? cpu_wr_data : '0;
        end else if (state == EXT_WR) begin
            ram_wen    = sel_q;
            ram_w_addr = addr_q;
            ram_w_data = wdata_q;
        end
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state   <= IDLE;
            sel_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nx;
            if (ext_go) begin
                sel_q   <= ext_sel;
                addr_q  <= ext_addr;
                wdata_q <= ext_wdata;
            end
            if (ext_rvalid) rdata_q <= ram_r_data;
        end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter against a behavioural RAM
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_rd_req = 1'b0;
    logic [31:0] cpu_rd_addr = '0;
    logic [3:0]  cpu_wr_sel = '0;
    logic [31:0] cpu_wr_addr = '0;
    logic [31:0] cpu_wr_data = '0;
    logic [31:0] cpu_rd_data;
    logic        cpu_stall;
    logic        ext_req = 1'b0;
    logic        ext_we = 1'b0;
    logic [3:0]  ext_sel = '0;
    logic [31:0] ext_addr = '0;
    logic [31:0] ext_wdata = '0;
    logic        ext_gnt, ext_rvalid;
    logic [31:0] ext_rdata;
    logic        ram_ren;
    logic [31:0] ram_r_addr, ram_w_addr, ram_w_data;
    logic [3:0]  ram_wen;
    logic [31:0] ram_r_data;
    logic [31:0] mem [0:255];
    int p = 0;
    int n = 0;

    mem_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_rd_req(cpu_rd_req), .cpu_rd_addr(cpu_rd_addr),
        .cpu_wr_sel(cpu_wr_sel), .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
        .cpu_rd_data(cpu_rd_data), .cpu_stall(cpu_stall),
        .ext_req(ext_req), .ext_we(ext_we), .ext_sel(ext_sel), .ext_addr(ext_addr),
        .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
        .ram_ren(ram_ren), .ram_r_addr(ram_r_addr), .ram_wen(ram_wen),
        .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data), .ram_r_data(ram_r_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            mem[4] <= 32'h1234_5678;
            ram_r_data <= '0;
        end else begin
            if (ram_ren) ram_r_data <= mem[ram_r_addr[9:2]];
            for (int i = 0; i < 4; i++)
                if (ram_wen[i]) mem[ram_w_addr[9:2]][8*i +: 8] <= ram_w_data[8*i +: 8];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n++; if (ext_gnt !== 1'b0) $display("FAIL rst_gnt: got %b want 0", ext_gnt); else p++;
        n++; if (ext_rvalid !== 1'b0) $display("FAIL rst_rvalid: got %b want 0", ext_rvalid); else p++;
        n++; if (ext_rdata !== 32'h0) $display("FAIL rst_rdata: got %h want 0", ext_rdata); else p++;
        n++; if (cpu_stall !== 1'b0) $display("FAIL rst_stall: got %b want 0", cpu_stall); else p++;
        n++; if ({ram_ren, ram_wen} !== 5'b0) $display("FAIL rst_strobes: got %b want 0", {ram_ren, ram_wen}); else p++;
        n++; if (ram_r_addr !== 32'h0 || ram_w_addr !== 32'h0) $display("FAIL rst_addr: got %h/%h want 0/0", ram_r_addr, ram_w_addr); else p++;
        rst = 1'b1;
    endtask

    task automatic test_ext_write();
        ext_req = 1'b1; ext_we = 1'b1; ext_sel = 4'hF; ext_addr = 32'h20; ext_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        n++; if (ext_gnt !== 1'b1) $display("FAIL wr_gnt: got %b want 1", ext_gnt); else p++;
        n++; if (ram_wen !== 4'hF) $display("FAIL wr_wen: got %h want f", ram_wen); else p++;
        n++; if (ram_w_addr !== 32'h20) $display("FAIL wr_addr: got %h want 20", ram_w_addr); else p++;
        n++; if (ram_w_data !== 32'hDEAD_BEEF) $display("FAIL wr_data: got %h want deadbeef", ram_w_data); else p++;
        tick();
        ext_req = 1'b0; ext_we = 1'b0; ext_sel = '0; ext_addr = '0; ext_wdata = '0;
        @(negedge clk);
        n++; if (ext_gnt !== 1'b0) $display("FAIL wr_gnt_pulse: got %b want 0", ext_gnt); else p++;
        n++; if (ram_wen !== 4'hF) $display("FAIL wr_latched_wen: got %h want f", ram_wen); else p++;
        tick();
        cpu_rd_req = 1'b1; cpu_rd_addr = 32'h20;
        @(negedge clk);
        n++; if (ram_ren !== 1'b1 || cpu_stall !== 1'b0) $display("FAIL wr_rb_issue: got ren=%b stall=%b want 1/0", ram_ren, cpu_stall); else p++;
        tick();
        cpu_rd_req = 1'b0;
        @(negedge clk);
        n++; if (cpu_rd_data !== 32'hDEAD_BEEF) $display("FAIL wr_readback: got %h want deadbeef", cpu_rd_data); else p++;
        tick();
    endtask

    task automatic test_cpu_read();
        cpu_rd_req = 1'b1; cpu_rd_addr = 32'h10;
        @(negedge clk);
        n++; if (ram_ren !== 1'b1) $display("FAIL rd_ren: got %b want 1", ram_ren); else p++;
        n++; if (ram_r_addr !== 32'h10) $display("FAIL rd_addr: got %h want 10", ram_r_addr); else p++;
        n++; if (cpu_stall !== 1'b0) $display("FAIL rd_stall: got %b want 0", cpu_stall); else p++;
        tick();
        cpu_rd_req = 1'b0; cpu_rd_addr = '0;
        @(negedge clk);
        n++; if (cpu_rd_data !== 32'h1234_5678) $display("FAIL rd_data: got %h want 12345678", cpu_rd_data); else p++;
        n++; if (ram_ren !== 1'b0 || ram_r_addr !== 32'h0) $display("FAIL rd_idle: got ren=%b addr=%h want 0/0", ram_ren, ram_r_addr); else p++;
        tick();
    endtask

    task automatic test_dual();
        cpu_rd_req = 1'b1; cpu_rd_addr = 32'h10;
        cpu_wr_sel = 4'b1100; cpu_wr_addr = 32'h30; cpu_wr_data = 32'hA5A5_1234;
        @(negedge clk);
        n++; if (ram_ren !== 1'b1 || ram_wen !== 4'b1100) $display("FAIL dual_strobes: got ren=%b wen=%b want 1/1100", ram_ren, ram_wen); else p++;
        n++; if (ram_w_addr !== 32'h30 || cpu_stall !== 1'b0) $display("FAIL dual_waddr: got %h stall=%b want 30/0", ram_w_addr, cpu_stall); else p++;
        tick();
        cpu_rd_addr = 32'h30; cpu_wr_sel = '0; cpu_wr_addr = '0; cpu_wr_data = '0;
        @(negedge clk);
        n++; if (cpu_rd_data !== 32'h1234_5678) $display("FAIL dual_rd: got %h want 12345678", cpu_rd_data); else p++;
        tick();
        cpu_rd_req = 1'b0; cpu_rd_addr = '0;
        @(negedge clk);
        n++; if (cpu_rd_data !== 32'hA5A5_0000) $display("FAIL dual_wr_bytes: got %h want a5a50000", cpu_rd_data); else p++;
        tick();
    endtask

    task automatic test_starve();
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h10;
        cpu_rd_req = 1'b1; cpu_rd_addr = 32'h20;
`ifdef MEM_ARB_STARVE_EN
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n++; if (ext_gnt !== 1'b0 || cpu_stall !== 1'b0) $display("FAIL starve_cpu_win%0d: got gnt=%b stall=%b want 0/0", i, ext_gnt, cpu_stall); else p++;
            tick();
        end
        @(negedge clk);
        n++; if (ext_gnt !== 1'b1 || cpu_stall !== 1'b1) $display("FAIL starve_force: got gnt=%b stall=%b want 1/1", ext_gnt, cpu_stall); else p++;
        n++; if (ram_r_addr !== 32'h10) $display("FAIL starve_addr: got %h want 10", ram_r_addr); else p++;
        tick();
        ext_req = 1'b0; ext_addr = '0;
        @(negedge clk);
        n++; if (ext_rvalid !== 1'b1 || ext_rdata !== 32'h1234_5678) $display("FAIL starve_rvalid: got %b %h want 1 12345678", ext_rvalid, ext_rdata); else p++;
        n++; if (cpu_stall !== 1'b1) $display("FAIL starve_rd_stall: got %b want 1", cpu_stall); else p++;
        tick();
        @(negedge clk);
        n++; if (ext_rvalid !== 1'b0 || cpu_stall !== 1'b0) $display("FAIL starve_after: got rvalid=%b stall=%b want 0/0", ext_rvalid, cpu_stall); else p++;
        tick();
        cpu_rd_req = 1'b0; cpu_rd_addr = '0;
`else
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n++; if (ext_gnt !== 1'b0 || cpu_stall !== 1'b0) $display("FAIL prio_cpu_win%0d: got gnt=%b stall=%b want 0/0", i, ext_gnt, cpu_stall); else p++;
            tick();
        end
        cpu_rd_req = 1'b0; cpu_rd_addr = '0;
        @(negedge clk);
        n++; if (ext_gnt !== 1'b1 || ram_r_addr !== 32'h10) $display("FAIL prio_gnt: got gnt=%b addr=%h want 1/10", ext_gnt, ram_r_addr); else p++;
        tick();
        ext_req = 1'b0; ext_addr = '0;
        @(negedge clk);
        n++; if (ext_rvalid !== 1'b1 || ext_rdata !== 32'h1234_5678) $display("FAIL prio_rvalid: got %b %h want 1 12345678", ext_rvalid, ext_rdata); else p++;
        tick();
`endif
        tick();
    endtask

    task automatic test_withdrawn();
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h10;
        cpu_rd_req = 1'b1; cpu_rd_addr = 32'h10;
        @(negedge clk);
        n++; if (ext_gnt !== 1'b0) $display("FAIL wd_contend: got %b want 0", ext_gnt); else p++;
        tick();
        ext_req = 1'b0; ext_addr = '0; cpu_rd_req = 1'b0; cpu_rd_addr = '0;
        @(negedge clk);
        n++; if (ext_gnt !== 1'b0 || ram_ren !== 1'b0) $display("FAIL wd_nogrant: got gnt=%b ren=%b want 0/0", ext_gnt, ram_ren); else p++;
        tick();
        @(negedge clk);
        n++; if (ext_rvalid !== 1'b0) $display("FAIL wd_rvalid: got %b want 0", ext_rvalid); else p++;
        tick();
    endtask

    task automatic test_zero_sel();
        ext_req = 1'b1; ext_we = 1'b1; ext_sel = 4'h0; ext_addr = 32'h10; ext_wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        n++; if (ext_gnt !== 1'b1 || ram_wen !== 4'h0) $display("FAIL zs_gnt: got gnt=%b wen=%h want 1/0", ext_gnt, ram_wen); else p++;
        tick();
        ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
        @(negedge clk);
        n++; if (ram_wen !== 4'h0) $display("FAIL zs_wen: got %h want 0", ram_wen); else p++;
        tick();
        cpu_rd_req = 1'b1; cpu_rd_addr = 32'h10;
        tick();
        cpu_rd_req = 1'b0; cpu_rd_addr = '0;
        @(negedge clk);
        n++; if (cpu_rd_data !== 32'h1234_5678) $display("FAIL zs_unchanged: got %h want 12345678", cpu_rd_data); else p++;
        tick();
    endtask

    task automatic test_reset_during_rd();
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h20;
        @(negedge clk);
        n++; if (ext_gnt !== 1'b1) $display("FAIL rrd_gnt: got %b want 1", ext_gnt); else p++;
        tick();
        ext_req = 1'b0; ext_addr = '0;
        rst = 1'b0;
        #1;
        n++; if (ext_rvalid !== 1'b0 || ext_rdata !== 32'h0) $display("FAIL rrd_rvalid: got %b %h want 0 0", ext_rvalid, ext_rdata); else p++;
        n++; if ({ram_ren, ram_wen, cpu_stall} !== 6'b0) $display("FAIL rrd_strobes: got %b want 0", {ram_ren, ram_wen, cpu_stall}); else p++;
        tick();
        rst = 1'b1;
        cpu_rd_req = 1'b1; cpu_rd_addr = 32'h10;
        @(negedge clk);
        n++; if (ext_rvalid !== 1'b0) $display("FAIL rrd_no_pulse: got %b want 0", ext_rvalid); else p++;
        n++; if (cpu_stall !== 1'b0 || ram_ren !== 1'b1) $display("FAIL rrd_idle: got stall=%b ren=%b want 0/1", cpu_stall, ram_ren); else p++;
        tick();
        cpu_rd_req = 1'b0; cpu_rd_addr = '0;
        @(negedge clk);
        n++; if (cpu_rd_data !== 32'h1234_5678) $display("FAIL rrd_cpu_rd: got %h want 12345678", cpu_rd_data); else p++;
        tick();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_ext_write();
        test_cpu_read();
        test_dual();
        test_starve();
        test_withdrawn();
        test_zero_sel();
        test_reset_during_rd();
        $display("%0d/%0d checks passed", p, n);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4, is the number of consecutive contended CPU grants allowed before the external port is forced through (range 1..15).
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 cpu_rd_req, cpu_rd_addr  in  1, 32  CPU load request and byte address.
REQ-005 cpu_wr_sel, cpu_wr_addr, cpu_wr_data  in  4, 32, 32  CPU store byte enables (any bit set = write request), address, data.
REQ-006 cpu_rd_data  out  32  RAM read data returned to the CPU.
REQ-007 cpu_stall  out  1  CPU access not accepted this cycle; CPU holds its request.
REQ-008 ext_req, ext_we, ext_sel, ext_addr, ext_wdata  in  1, 1, 4, 32, 32  external (loader/debug) access request.
REQ-009 ext_gnt  out  1  one-cycle pulse: external access accepted this cycle.
REQ-010 ext_rvalid, ext_rdata  out  1, 32  external read data valid pulse and data.
REQ-011 ram_ren, ram_r_addr, ram_wen, ram_w_addr, ram_w_data  out  1, 32, 4, 32, 32  to data RAM.
REQ-012 ram_r_data  in  32  RAM read data, valid one cycle after ram_ren.

Function
REQ-013 Arbiter shall hold FSM states IDLE, CPU_OWN, EXT_RD, EXT_WR.
REQ-014 In IDLE or CPU_OWN with no ext_req, CPU requests shall pass combinationally to the RAM port with cpu_stall=0.
REQ-015 Contention (CPU request and ext_req same cycle): CPU shall win unless the starvation counter equals STARVE_MAX.
REQ-016 Starvation counter (4 bits) shall increment on each contended CPU win, saturate at STARVE_MAX, clear on any ext_gnt.
REQ-017 ext_gnt shall pulse in the cycle the external command is driven to the RAM; next state EXT_RD if ext_we=0, else EXT_WR.
REQ-018 EXT_WR shall last one cycle, ram_wen=ext_sel latched at grant; then return to IDLE.
REQ-019 EXT_RD: ext_rvalid=1 and ext_rdata=ram_r_data exactly one cycle after ext_gnt; cpu_stall=1 during EXT_RD if CPU requests; then IDLE.
REQ-020 During any external grant cycle a pending CPU request shall see cpu_stall=1 and ram_ren/ram_wen shall carry only the external command.
REQ-021 cpu_rd_data shall equal ram_r_data in the cycle after a granted CPU read; CPU read latency 1 cycle, write latency 0.
REQ-022 CPU read and write in the same cycle shall both be issued (separate RAM read/write ports).
REQ-023 ext_req deasserted before ext_gnt shall be treated as withdrawn; no grant issued.
REQ-024 ext_sel=0 with ext_we=1 shall still grant and complete with ram_wen=0.
REQ-025 Idle outputs: ram_ren=0, ram_wen=0, addresses/data 0.

Reset
REQ-026 rst low shall force IDLE, starvation counter 0, ext_gnt=0, ext_rvalid=0, ext_rdata=0, cpu_stall=0, all RAM strobes 0, asynchronously.
REQ-027 Reset during EXT_RD shall drop the pending ext_rvalid; no pulse after release.
REQ-028 First grant shall be possible in the first rising edge after rst deasserts.

Configuration
REQ-029 Macro MEM_ARB_STARVE_EN: defined, starvation counter and forced external grant per REQ-015/016 are present.
REQ-030 Without MEM_ARB_STARVE_EN: strict CPU priority, no counter; ext is granted only in cycles with no CPU request; STARVE_MAX unused.

Structure
REQ-031 Shared package mem_arb_pkg shall hold FSM state enum (IDLE, CPU_OWN, EXT_RD, EXT_WR), address/data width constants (32) and byte-enable width (4).
REQ-032 Starvation counter shall be a sub-module mem_arb_starve_cnt (inc, clr, sat output), instantiated only under MEM_ARB_STARVE_EN.
REQ-033 Arbitration decision combinational; FSM, counter, ext_rdata capture registered.

Verification
REQ-034 CPU read addr 0x10, no ext -> ram_ren=1 same cycle, cpu_stall=0, cpu_rd_data=RAM[0x10] next cycle.
REQ-035 ext write addr 0x20 data 0xDEADBEEF sel 0xF, CPU idle -> ext_gnt=1 same cycle, ram_wen=0xF, readback via CPU returns 0xDEADBEEF.
REQ-036 ext read held + CPU reads every cycle, STARVE_EN, STARVE_MAX=4 -> 4 CPU grants, 5th cycle ext_gnt=1 with cpu_stall=1, ext_rvalid next cycle.
REQ-037 Same stimulus without MEM_ARB_STARVE_EN -> ext_gnt never asserts until CPU request drops; then ext_gnt in that cycle.
REQ-038 rst low in cycle after ext read grant -> ext_rvalid stays 0, FSM IDLE, all strobes 0.
REQ-039 ext_we=1 sel=0x0 -> ext_gnt pulses, ram_wen=0, RAM contents unchanged.
